// File: rtl/reg_wb_arbiter_if.sv
// Write-request bus between the two writeback sources, the arbiter and reg_bank's write port.
interface reg_wb_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              A_VALID;
    logic              A_READY;
    logic [ADDR_W-1:0] A_ADDR;
    logic [WIDTH-1:0]  A_DATA;
    logic              B_VALID;
    logic              B_READY;
    logic [ADDR_W-1:0] B_ADDR;
    logic [WIDTH-1:0]  B_DATA;
    logic              WE3;
    logic [ADDR_W-1:0] RA3;
    logic [WIDTH-1:0]  WD3;
    logic              BUSY;

    modport slave (
        input  A_VALID, A_ADDR, A_DATA,
        input  B_VALID, B_ADDR, B_DATA,
        output A_READY, B_READY,
        output WE3, RA3, WD3, BUSY
    );

    modport master (
        output A_VALID, A_ADDR, A_DATA,
        output B_VALID, B_ADDR, B_DATA,
        input  A_READY, B_READY,
        input  WE3, RA3, WD3, BUSY
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Two-source writeback arbiter: per-source FIFOs drained round-robin into reg_bank's
// single registered write port (WE3/RA3/WD3).
module reg_wb_arbiter #(
    parameter int WIDTH      = 32,
    parameter int TOTAL_REGS = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    reg_wb_arbiter_if.slave   bus
);
    localparam int ENTRY_W = ADDR_W + WIDTH;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;

    if (ADDR_W != $clog2(TOTAL_REGS)) begin : g_addr_w_check
        $error("reg_wb_arbiter: ADDR_W must equal clog2(TOTAL_REGS)");
    end

    logic [1:0]              src_valid;
    logic [1:0][ENTRY_W-1:0] src_entry;
    logic [1:0][ENTRY_W-1:0] head;
    logic [1:0]              ready;
    logic [1:0]              empty;
    logic [1:0]              push;
    logic [1:0]              grant;

    src_t              prio_reg, prio_next;
    logic              we3_reg;
    logic [ADDR_W-1:0] ra3_reg;
    logic [WIDTH-1:0]  wd3_reg;

    assign src_valid    = {bus.B_VALID, bus.A_VALID};
    assign src_entry[0] = {bus.A_ADDR, bus.A_DATA};
    assign src_entry[1] = {bus.B_ADDR, bus.B_DATA};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ENTRY_W-1:0] mem_reg [DEPTH];
            logic [PTR_W-1:0]   wr_ptr_reg;
            logic [PTR_W-1:0]   rd_ptr_reg;
            logic [CNT_W-1:0]   count_reg;

            // Ready looks only at the registered count, so a full FIFO refuses
            // a push even in the cycle its head is popped.
            assign ready[gi] = (count_reg < CNT_W'(DEPTH));
            assign empty[gi] = (count_reg == '0);
            assign push[gi]  = src_valid[gi] & ready[gi];
            assign head[gi]  = mem_reg[rd_ptr_reg];

            always_ff @(posedge CLK) begin
                if (push[gi]) begin
                    mem_reg[wr_ptr_reg] <= src_entry[gi];
                end
            end

            // DEPTH is a power of two, so pointers wrap by plain overflow.
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (grant[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    case ({push[gi], grant[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Any grant hands priority to the other source; idle cycles leave it alone.
    always_comb begin
        grant     = 2'b00;
        prio_next = prio_reg;
        if (!empty[0] && (empty[1] || prio_reg == SRC_A)) begin
            grant     = 2'b01;
            prio_next = SRC_B;
        end else if (!empty[1]) begin
            grant     = 2'b10;
            prio_next = SRC_A;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            prio_reg <= SRC_A;
            we3_reg  <= 1'b0;
            ra3_reg  <= '0;
            wd3_reg  <= '0;
        end else begin
            prio_reg <= prio_next;
            we3_reg  <= |grant;
            if (grant[0]) begin
                {ra3_reg, wd3_reg} <= head[0];
            end else if (grant[1]) begin
                {ra3_reg, wd3_reg} <= head[1];
            end
        end
    end

    assign bus.A_READY = ready[0];
    assign bus.B_READY = ready[1];
    assign bus.WE3     = we3_reg;
    assign bus.RA3     = ra3_reg;
    assign bus.WD3     = wd3_reg;
    assign bus.BUSY    = we3_reg | ~(&empty);
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: per-source expected queues are filled on accept
// and drained when WE3 issues; a local register-bank model records the writes.
module tb_reg_wb_arbiter;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    typedef logic [ADDR_W+WIDTH-1:0] txn_t;

    logic CLK;
    logic RST_N;

    reg_wb_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg_wb_arbiter #(
        .WIDTH(WIDTH), .TOTAL_REGS(NREGS), .ADDR_W(ADDR_W), .DEPTH(2)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    txn_t sb_a[$];
    txn_t sb_b[$];
    txn_t send_a[$];
    txn_t send_b[$];
    bit   src_log[$];
    int   issue_cyc[$];
    logic [WIDTH-1:0] bank [NREGS];
    bit   last_acc_a, last_acc_b;
    bit   b_stalled;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample pre-edge state, apply the edge to the model, then retire/accept.
    task automatic cycle();
        logic              we;
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  wd;
        bit                in_rst;
        txn_t              a_txn, b_txn;
        we     = bus.WE3;
        ra     = bus.RA3;
        wd     = bus.WD3;
        in_rst = !RST_N;
        a_txn  = {bus.A_ADDR, bus.A_DATA};
        b_txn  = {bus.B_ADDR, bus.B_DATA};
        last_acc_a = bus.A_VALID && bus.A_READY && !in_rst;
        last_acc_b = bus.B_VALID && bus.B_READY && !in_rst;
        if (bus.B_VALID && !bus.B_READY) b_stalled = 1'b1;
        @(posedge CLK);
        if (we === 1'b1) begin
            bank[ra] = wd;
            if (sb_a.size() != 0 && sb_a[0] == {ra, wd}) begin
                check_val("we3_src_a", {ra, wd}, sb_a.pop_front());
                src_log.push_back(1'b0);
                issue_cyc.push_back(cyc);
                $display("[TB] cyc %0d write A addr=%0d data=%0d", cyc, ra, wd);
            end else if (sb_b.size() != 0) begin
                check_val("we3_src_b", {ra, wd}, sb_b.pop_front());
                src_log.push_back(1'b1);
                issue_cyc.push_back(cyc);
                $display("[TB] cyc %0d write B addr=%0d data=%0d", cyc, ra, wd);
            end else begin
                check_val("we3_spurious", {ra, wd}, 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        if (last_acc_a) sb_a.push_back(a_txn);
        if (last_acc_b) sb_b.push_back(b_txn);
        if (in_rst) begin
            sb_a.delete();
            sb_b.delete();
        end
        cyc++;
        #1;
    endtask

    task automatic drive_heads();
        if (send_a.size() != 0) begin
            bus.A_VALID = 1'b1;
            {bus.A_ADDR, bus.A_DATA} = send_a[0];
        end else begin
            bus.A_VALID = 1'b0;
            bus.A_ADDR  = ADDR_W'($urandom);
            bus.A_DATA  = $urandom;
        end
        if (send_b.size() != 0) begin
            bus.B_VALID = 1'b1;
            {bus.B_ADDR, bus.B_DATA} = send_b[0];
        end else begin
            bus.B_VALID = 1'b0;
            bus.B_ADDR  = ADDR_W'($urandom);
            bus.B_DATA  = $urandom;
        end
    endtask

    task automatic step_send();
        drive_heads();
        cycle();
        if (last_acc_a) void'(send_a.pop_front());
        if (last_acc_b) void'(send_b.pop_front());
    endtask

    task automatic run_streams(input string tag, input int budget);
        int n;
        n = 0;
        while ((send_a.size() != 0 || send_b.size() != 0 || sb_a.size() != 0 ||
                sb_b.size() != 0 || bus.WE3 !== 1'b0) && n < budget) begin
            step_send();
            n++;
        end
        bus.A_VALID = 1'b0;
        bus.B_VALID = 1'b0;
        check_val({tag, "_drained"}, 64'(n < budget), 64'd1);
        check_val({tag, "_busy_idle"}, 64'(bus.BUSY), 64'd0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        bus.A_VALID = 1'b0;
        bus.B_VALID = 1'b0;
        cycle();
        cycle();
        RST_N = 1'b1;
    endtask

    initial begin
        int na, nb;
        RST_N = 1'b0;
        bus.A_VALID = 1'b0; bus.A_ADDR = '0; bus.A_DATA = '0;
        bus.B_VALID = 1'b0; bus.B_ADDR = '0; bus.B_DATA = '0;
        for (int i = 0; i < NREGS; i++) bank[i] = '0;
        b_stalled = 1'b0;

        // Reset state
        do_reset();
        check_val("rst_we3", 64'(bus.WE3), 64'd0);
        check_val("rst_ra3", 64'(bus.RA3), 64'd0);
        check_val("rst_wd3", 64'(bus.WD3), 64'd0);
        check_val("rst_a_ready", 64'(bus.A_READY), 64'd1);
        check_val("rst_b_ready", 64'(bus.B_READY), 64'd1);
        check_val("rst_busy", 64'(bus.BUSY), 64'd0);

        // Single write: accepted at edge k, WE3 visible only after edge k+1
        bus.A_VALID = 1'b1; bus.A_ADDR = 5'd3; bus.A_DATA = 32'd100;
        cycle();
        bus.A_VALID = 1'b0;
        check_val("t1_we3_after_k", 64'(bus.WE3), 64'd0);
        check_val("t1_busy_queued", 64'(bus.BUSY), 64'd1);
        cycle();
        check_val("t1_we3", 64'(bus.WE3), 64'd1);
        check_val("t1_ra3", 64'(bus.RA3), 64'd3);
        check_val("t1_wd3", 64'(bus.WD3), 64'd100);
        cycle();
        check_val("t1_we3_one_cycle", 64'(bus.WE3), 64'd0);
        check_val("t1_bank3", 64'(bank[3]), 64'd100);

        // Contention from reset: strict A,B alternation with no gaps
        do_reset();
        src_log.delete(); issue_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            send_a.push_back({5'(1 + i), 32'(200 + i)});
            send_b.push_back({5'(11 + i), 32'(300 + i)});
        end
        run_streams("t2", 60);
        check_val("t2_issues", 64'(src_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < src_log.size(); i++) begin
            check_val($sformatf("t2_src_%0d", i), 64'(src_log[i]), 64'(i % 2));
            check_val($sformatf("t2_gap_%0d", i), 64'(issue_cyc[i] - issue_cyc[0]), 64'(i));
        end

        // Backpressure on B while A streams
        src_log.delete(); issue_cyc.delete();
        b_stalled = 1'b0;
        for (int i = 0; i < 6; i++) send_a.push_back({5'(20 + i), 32'(500 + i)});
        for (int i = 0; i < 5; i++) send_b.push_back({5'(5 + i), 32'(400 + i)});
        run_streams("t3", 80);
        na = 0; nb = 0;
        foreach (src_log[i]) if (src_log[i]) nb++; else na++;
        check_val("t3_b_stalled", 64'(b_stalled), 64'd1);
        check_val("t3_b_count", 64'(nb), 64'd5);
        check_val("t3_a_count", 64'(na), 64'd6);
        for (int i = 0; i < 5; i++) check_val($sformatf("t3_bank_%0d", 5 + i), 64'(bank[5 + i]), 64'(400 + i));

        // Full FIFO refuses a push in the cycle its head pops
        do_reset();
        bus.A_VALID = 1'b1; bus.A_ADDR = 5'd15; bus.A_DATA = 32'd600;
        cycle();
        bus.A_ADDR = 5'd16; bus.A_DATA = 32'd601;
        bus.B_VALID = 1'b1; bus.B_ADDR = 5'd19; bus.B_DATA = 32'd700;
        cycle();
        bus.A_ADDR = 5'd17; bus.A_DATA = 32'd602;
        bus.B_ADDR = 5'd10; bus.B_DATA = 32'd701;
        cycle();
        bus.A_ADDR = 5'd18; bus.A_DATA = 32'd603;
        bus.B_VALID = 1'b0;
        check_val("t4_full_ready", 64'(bus.A_READY), 64'd0);
        cycle();
        check_val("t4_full_refused", 64'(last_acc_a), 64'd0);
        check_val("t4_ready_again", 64'(bus.A_READY), 64'd1);
        cycle();
        check_val("t4_push_after", 64'(last_acc_a), 64'd1);
        bus.A_VALID = 1'b0;
        run_streams("t4", 40);
        check_val("t4_bank18", 64'(bank[18]), 64'd603);

        // Reset mid-stream drops queued writes; in-flight WE3 still lands
        do_reset();
        send_a.push_back({5'd26, 32'd800}); send_a.push_back({5'd27, 32'd801});
        send_b.push_back({5'd28, 32'd802}); send_b.push_back({5'd29, 32'd803});
        step_send();
        step_send();
        check_val("t5_we3_inflight", 64'(bus.WE3), 64'd1);
        send_a.delete(); send_b.delete();
        RST_N = 1'b0;
        bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
        cycle();
        check_val("t5_we3", 64'(bus.WE3), 64'd0);
        check_val("t5_busy", 64'(bus.BUSY), 64'd0);
        check_val("t5_a_ready", 64'(bus.A_READY), 64'd1);
        check_val("t5_b_ready", 64'(bus.B_READY), 64'd1);
        RST_N = 1'b1;
        repeat (4) cycle();
        check_val("t5_bank26", 64'(bank[26]), 64'd800);
        check_val("t5_bank27", 64'(bank[27]), 64'd0);
        check_val("t5_bank28", 64'(bank[28]), 64'd0);
        check_val("t5_bank29", 64'(bank[29]), 64'd0);

        // Full sweep, register 0 included
        for (int i = 0; i < NREGS; i++) begin
            if (i % 2 == 0) send_a.push_back({5'(i), 32'(100 + i)});
            else            send_b.push_back({5'(i), 32'(100 + i)});
        end
        run_streams("t6", 200);
        for (int i = 0; i < NREGS; i++) check_val($sformatf("t6_bank_%0d", i), 64'(bank[i]), 64'(100 + i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
